clk_read_port: RTL and testbench

Read-side companion to the real-clock load path. Takes a coherent snapshot of the running seconds/minutes/hours counts into a shadow register bank, guarding against tearing around counter updates, then returns shadow values through an addressed, registered read port with a valid strobe. Sits beside the top-level clock, fed by the time-base terminal-count pulse and the counter outputs, and serves a host or display controller.

---
 rtl/clk_read_port_if.sv | 22 ++
 rtl/clk_read_port.sv | 175 +++++++++++++++++
 tb/tb_clk_read_port.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_read_port_if.sv
// Host-facing bus of the clock read port: snapshot request/status and the
// addressed, registered read channel. The host drives the master side,
// clk_read_port sits on the slave side.
interface clk_read_port_if;
    logic       snap_req;   // request a new coherent snapshot
    logic       rd_en;      // read strobe
    logic [1:0] rd_addrs;   // 00 sec, 01 min, 10 hr, 11 status
    logic [5:0] rd_data;    // registered read data
    logic       rd_valid;   // high the cycle after an accepted rd_en
    logic       busy;       // snapshot pending
    logic       snap_done;  // one-cycle pulse after a shadow update

    modport master (
        output snap_req, rd_en, rd_addrs,
        input  rd_data, rd_valid, busy, snap_done
    );

    modport slave (
        input  snap_req, rd_en, rd_addrs,
        output rd_data, rd_valid, busy, snap_done
    );
endinterface

// File: rtl/clk_read_port.sv
// Read-side companion of the real-time clock. Captures a coherent snapshot
// of the live seconds/minutes/hours counts into a shadow bank, avoiding the
// two edges around a time-base terminal count where the counters may be
// mid-update, and serves the shadow values through a registered read port.
module clk_read_port #(
    parameter int SEC_W = 6,
    parameter int MIN_W = 6,
    parameter int HR_W  = 5
) (
    input  logic             clk,
    input  logic             reset,         // synchronous, active-low
    input  logic             tc_time_base,  // counters step on this edge and the next
    input  logic [SEC_W-1:0] seconds_in,
    input  logic [MIN_W-1:0] minutes_in,
    input  logic [HR_W-1:0]  hours_in,
    clk_read_port_if.slave   bus
);

    // The read bus is 6 bits wide; every count must fit in it.
    if (SEC_W > 6 || MIN_W > 6 || HR_W > 6) begin : g_width_check
        $error("clk_read_port: SEC_W, MIN_W and HR_W must each be <= 6");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [1:0] ADDR_SEC    = 2'b00;
    localparam logic [1:0] ADDR_MIN    = 2'b01;
    localparam logic [1:0] ADDR_HR     = 2'b10;
    localparam logic [1:0] ADDR_STATUS = 2'b11;

    // ------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic             tc_d_q;

    logic [SEC_W-1:0] shadow_sec_q, shadow_sec_d;
    logic [MIN_W-1:0] shadow_min_q, shadow_min_d;
    logic [HR_W-1:0]  shadow_hr_q,  shadow_hr_d;
    logic             snap_valid_q, snap_valid_d;
    logic             stale_q,      stale_d;
    logic             snap_done_q,  snap_done_d;
    logic [5:0]       rd_data_q,    rd_data_d;
    logic             rd_valid_q,   rd_valid_d;

    // FSM outputs
    logic             busy;
    logic             capture;

    // Capture is safe only when neither this edge nor the previous one
    // carried a terminal count, i.e. no counter is stepping right now.
    logic             safe;
    assign safe = !tc_time_base && !tc_d_q;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // Advance the snapshot FSM; reset discards any pending request.
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // IDLE waits for a request; WAIT waits for a safe edge, ignoring
    // further requests so they never queue.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d
        // unassigned, which would infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.snap_req) state_d = ST_WAIT;
            ST_WAIT: if (safe)         state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    // busy covers the whole WAIT stay; capture fires on the safe edge.
    always_comb begin
        busy    = 1'b0;
        capture = 1'b0;
        if (state_q == ST_WAIT) begin
            busy    = 1'b1;
            capture = safe;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next-state: shadow bank, status flags, read port
    // ------------------------------------------------------------------
    // Shadow loads on capture; stale flags a terminal count seen after a
    // valid snapshot; the read mux looks at the pre-capture shadow.
    always_comb begin
        shadow_sec_d = shadow_sec_q;
        shadow_min_d = shadow_min_q;
        shadow_hr_d  = shadow_hr_q;
        snap_valid_d = snap_valid_q;
        stale_d      = stale_q;
        snap_done_d  = capture;
        rd_valid_d   = bus.rd_en;
        rd_data_d    = rd_data_q;

        if (capture) begin
            shadow_sec_d = seconds_in;
            shadow_min_d = minutes_in;
            shadow_hr_d  = hours_in;
            snap_valid_d = 1'b1;
            stale_d      = 1'b0;
        end else if (tc_time_base && snap_valid_q) begin
            stale_d      = 1'b1;
        end

        if (bus.rd_en) begin
            case (bus.rd_addrs)
                ADDR_SEC:    rd_data_d = 6'(shadow_sec_q);
                ADDR_MIN:    rd_data_d = 6'(shadow_min_q);
                ADDR_HR:     rd_data_d = 6'(shadow_hr_q);
                ADDR_STATUS: rd_data_d = {4'b0000, stale_q, snap_valid_q};
                default:     rd_data_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Register shadow bank, flags, terminal-count delay and read outputs.
    always_ff @(posedge clk) begin
        // NOTE: the shadow bank is a handful of flops, not a RAM, and a
        // read of it must return zero after reset, so it is reset too.
        if (!reset) begin
            tc_d_q       <= 1'b0;
            shadow_sec_q <= '0;
            shadow_min_q <= '0;
            shadow_hr_q  <= '0;
            snap_valid_q <= 1'b0;
            stale_q      <= 1'b0;
            snap_done_q  <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            tc_d_q       <= tc_time_base;
            shadow_sec_q <= shadow_sec_d;
            shadow_min_q <= shadow_min_d;
            shadow_hr_q  <= shadow_hr_d;
            snap_valid_q <= snap_valid_d;
            stale_q      <= stale_d;
            snap_done_q  <= snap_done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs
    // ------------------------------------------------------------------
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.busy      = busy;
    assign bus.snap_done = snap_done_q;

endmodule

// File: tb/tb_clk_read_port.sv
// Directed bench for clk_read_port. Read expectations are pushed to a
// scoreboard queue when rd_en is driven and popped when rd_valid returns.
module tb_clk_read_port;

    localparam int SEC_W = 6;
    localparam int MIN_W = 6;
    localparam int HR_W  = 5;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tc = 1'b0;
    logic [SEC_W-1:0] sec = '0;
    logic [MIN_W-1:0] min = '0;
    logic [HR_W-1:0]  hr  = '0;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [5:0] exp_q[$];

    always #5 clk = ~clk;

    clk_read_port_if bus ();

    clk_read_port #(
        .SEC_W (SEC_W),
        .MIN_W (MIN_W),
        .HR_W  (HR_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tc_time_base (tc),
        .seconds_in   (sec),
        .minutes_in   (min),
        .hours_in     (hr),
        .bus          (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are driven and outputs sampled 1 time unit
    // after the rising edge. Any read accepted at this edge is scored here.
    task automatic tick();
        logic exp_v;
        exp_v = bus.rd_en && reset;
        @(posedge clk);
        #1;
        check("rd_valid", {31'b0, bus.rd_valid}, {31'b0, exp_v});
        if (exp_v) begin
            check("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check("rd_data", {26'b0, bus.rd_data}, {26'b0, exp_q.pop_front()});
        end
    endtask

    task automatic rd(input logic [1:0] addr, input logic [5:0] exp);
        bus.rd_en    = 1'b1;
        bus.rd_addrs = addr;
        exp_q.push_back(exp);
        tick();
        bus.rd_en    = 1'b0;
    endtask

    task automatic chk_ctl(input string tag, input logic exp_busy, input logic exp_done);
        check({tag, "_busy"}, {31'b0, bus.busy}, {31'b0, exp_busy});
        check({tag, "_done"}, {31'b0, bus.snap_done}, {31'b0, exp_done});
    endtask

    initial begin
        int extra_done;

        // ---------------- reset with active requests ----------------
        bus.snap_req = 1'b1;
        bus.rd_en    = 1'b1;
        bus.rd_addrs = 2'b11;
        tick();
        tick();
        check("rst_rd_data", {26'b0, bus.rd_data}, 32'd0);
        chk_ctl("rst", 1'b0, 1'b0);
        reset        = 1'b1;
        bus.snap_req = 1'b0;
        bus.rd_en    = 1'b0;
        tick();
        chk_ctl("post_rst", 1'b0, 1'b0);
        rd(2'b11, 6'b000000);

        // ---------------- quiet snapshot ----------------
        sec = 6'd45; min = 6'd12; hr = 5'd23;
        bus.snap_req = 1'b1;
        tick();                               // edge N
        bus.snap_req = 1'b0;
        chk_ctl("quiet_n", 1'b1, 1'b0);
        tick();                               // N+1 capture
        chk_ctl("quiet_n1", 1'b0, 1'b1);
        tick();
        chk_ctl("quiet_n2", 1'b0, 1'b0);
        rd(2'b00, 6'd45);
        rd(2'b01, 6'd12);
        rd(2'b10, 6'd23);
        rd(2'b11, 6'b000001);

        // ---------------- collision with 59:59 rollover ----------------
        sec = 6'd59; min = 6'd59; hr = 5'd5;
        bus.snap_req = 1'b1;
        tick();                               // edge N
        bus.snap_req = 1'b0;
        tc = 1'b1;
        chk_ctl("coll_n", 1'b1, 1'b0);
        tick();                               // N+1: tc, seconds step
        tc  = 1'b0;
        sec = 6'd0;
        chk_ctl("coll_n1", 1'b1, 1'b0);
        tick();                               // N+2: minutes/hours step
        min = 6'd0;
        hr  = 5'd6;
        chk_ctl("coll_n2", 1'b1, 1'b0);
        tick();                               // N+3 capture
        chk_ctl("coll_n3", 1'b0, 1'b1);
        tick();
        chk_ctl("coll_n4", 1'b0, 1'b0);
        rd(2'b00, 6'd0);
        rd(2'b01, 6'd0);
        rd(2'b10, 6'd6);
        rd(2'b11, 6'b000001);

        // ---------------- stale flag ----------------
        sec = 6'd10; min = 6'd20; hr = 5'd3;
        tc = 1'b1;
        tick();
        tc = 1'b0;
        rd(2'b11, 6'b000011);
        bus.snap_req = 1'b1;
        tick();
        bus.snap_req = 1'b0;
        tick();                               // safe: capture
        chk_ctl("stale_cap", 1'b0, 1'b1);
        rd(2'b11, 6'b000001);
        rd(2'b00, 6'd10);

        // ---------------- read/capture overlap ----------------
        sec = 6'd33;
        bus.snap_req = 1'b1;
        tick();                               // edge N
        bus.snap_req = 1'b0;
        rd(2'b00, 6'd10);                     // read at capture edge: old value
        chk_ctl("ovl_cap", 1'b0, 1'b1);
        rd(2'b00, 6'd33);

        // ---------------- ignored request in WAIT ----------------
        sec = 6'd1; min = 6'd2; hr = 5'd4;
        bus.snap_req = 1'b1;
        tick();                               // edge N
        bus.snap_req = 1'b0;
        tc = 1'b1;
        tick();                               // N+1 blocked
        tc = 1'b0;
        bus.snap_req = 1'b1;
        chk_ctl("ign_n1", 1'b1, 1'b0);
        tick();                               // N+2 blocked, request ignored
        bus.snap_req = 1'b0;
        chk_ctl("ign_n2", 1'b1, 1'b0);
        tick();                               // N+3 capture
        chk_ctl("ign_n3", 1'b0, 1'b1);
        extra_done = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            extra_done += int'(bus.snap_done) + int'(bus.busy);
        end
        check("ign_extra", extra_done, 0);
        rd(2'b10, 6'd4);

        // ---------------- mid-operation reset ----------------
        bus.snap_req = 1'b1;
        tick();                               // enter WAIT
        bus.snap_req = 1'b0;
        tc = 1'b1;
        chk_ctl("mid_wait", 1'b1, 1'b0);
        reset = 1'b0;
        tick();                               // reset edge
        chk_ctl("mid_rst", 1'b0, 1'b0);
        check("mid_rst_rd", {26'b0, bus.rd_data}, 32'd0);
        reset = 1'b1;
        tc    = 1'b0;
        tick();
        chk_ctl("mid_after1", 1'b0, 1'b0);
        tick();
        chk_ctl("mid_after2", 1'b0, 1'b0);
        rd(2'b11, 6'b000000);
        rd(2'b00, 6'd0);
        rd(2'b10, 6'd0);

        check("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
